// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver: FSM encoding, frame layout,
// default generics and the odd-parity helper.
package ps2_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  // Frame layout
  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Default generics
  localparam int FRQ_DEF = 24000000;
  localparam int FLT_DEF = 8;
  localparam int TMO_DEF = FRQ_DEF / 5000;
  localparam int TMO_W   = $clog2(TMO_DEF);

  // Odd parity holds when data bits plus parity bit contain an odd number of ones
  function automatic logic odd_par_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FLT-sample glitch filter. The filtered
// line only flips after FLT consecutive synchronised samples disagree with it.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FLT = FLT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic line_o
);

  localparam int CW = $clog2(FLT + 1);

  logic          s1_q, s2_q;
  logic          line_q, line_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that differ from the filtered level
  always_comb begin
    line_d = line_q;
    cnt_d  = '0;
    if (s2_q != line_q) begin
      if (cnt_q == CW'(FLT - 1)) begin
        line_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser and filter state; idle bus level is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      line_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the pins, deframes 11-bit frames
// and hands good bytes to a one-entry valid/ready buffer.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FRQ = FRQ_DEF,
  parameter int FLT = FLT_DEF,
  parameter int TMO = FRQ / 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       err_par,
  output logic       err_frm,
  output logic       err_ovr
);

  localparam int TW = (TMO == TMO_DEF) ? TMO_W : $clog2(TMO);

  logic          clk_f, dat_f, clk_prev_q, fall;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    sh_q, sh_d;
  logic          pok_q, pok_d;
  logic [7:0]    dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          epar_q, epar_d, efrm_q, efrm_d, eovr_q, eovr_d;
  logic          deliver;

  ps2_line_filter #(.FLT(FLT)) u_clk_flt (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ps2_clk_i),
    .line_o (clk_f)
  );

  ps2_line_filter #(.FLT(FLT)) u_dat_flt (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ps2_dat_i),
    .line_o (dat_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  // Frame FSM, timeout supervision and buffer next-state
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tmo_d   = tmo_q;
    sh_d    = sh_q;
    pok_d   = pok_q;
    dat_d   = dat_q;
    vld_d   = vld_q;
    epar_d  = 1'b0;
    efrm_d  = 1'b0;
    eovr_d  = 1'b0;
    deliver = 1'b0;

    if (vld_q && rx_rdy) vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall && dat_f == START_LVL) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tmo_d   = '0;
        end
      end
      default: begin
        if (fall) begin
          tmo_d = '0;
          case (state_q)
            ST_DATA: begin
              sh_d  = {dat_f, sh_q[7:1]};
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_PAR;
            end
            ST_PAR: begin
              pok_d   = odd_par_ok(sh_q, dat_f);
              state_d = ST_STOP;
            end
            default: begin
              if (dat_f != STOP_LVL)  efrm_d  = 1'b1;
              else if (!pok_q)        epar_d  = 1'b1;
              else                    deliver = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end else if (tmo_q == TW'(TMO - 1)) begin
          efrm_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase

    // A byte loads when the buffer is empty or being drained this cycle
    if (deliver) begin
      if (!vld_q || rx_rdy) begin
        dat_d = sh_q;
        vld_d = 1'b1;
      end else begin
        eovr_d = 1'b1;
      end
    end
  end

  // Control state, buffer and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      tmo_q      <= '0;
      dat_q      <= '0;
      vld_q      <= 1'b0;
      epar_q     <= 1'b0;
      efrm_q     <= 1'b0;
      eovr_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      bit_q      <= bit_d;
      tmo_q      <= tmo_d;
      dat_q      <= dat_d;
      vld_q      <= vld_d;
      epar_q     <= epar_d;
      efrm_q     <= efrm_d;
      eovr_q     <= eovr_d;
    end
  end

  // Shift register and parity flag carry no reset; they are rewritten every frame
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    pok_q <= pok_d;
  end

  assign rx_dat  = dat_q;
  assign rx_vld  = vld_q;
  assign err_par = epar_q;
  assign err_frm = efrm_q;
  assign err_ovr = eovr_q;

endmodule
